// File: rtl/serdes_pkg.sv
// Shared K28.5 comma constants and receive-aligner state type for the SerDes lane.
// No logic: types and constants only, so no latency or backpressure.
package serdes_pkg;

   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} rx_state_t;

endpackage

// File: rtl/comma_aligner.sv
// Comma-based symbol aligner: emits a symbol one edge after it fills the window; locks and unlocks on comma runs.
// Has no backpressure: the output strobe is fire-and-forget.
module comma_aligner
   import serdes_pkg::*;
#(
   parameter int                  SYMBOL_W     = 10,
   parameter logic [SYMBOL_W-1:0] COMMA_P      = K28_5_RDN,
   parameter logic [SYMBOL_W-1:0] COMMA_N      = K28_5_RDP,
   parameter int                  LOCK_CNT     = 3,
   parameter int                  MISALIGN_CNT = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                bit_i,
   output logic [SYMBOL_W-1:0] data_o,
   output logic                valid_o,
   output logic                comma_o,
   output logic                locked_o
);

   localparam int PW = $clog2(SYMBOL_W);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(MISALIGN_CNT + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(SYMBOL_W - 1);

   logic [SYMBOL_W-1:0] win_q;
   logic [SYMBOL_W-1:0] data_q;
   logic [PW-1:0]       phase_q;
   logic [LW-1:0]       lock_cnt_q;
   logic [MW-1:0]       mis_cnt_q;
   rx_state_t           state_q;
   logic                valid_q;
   logic                comma_q;
   logic                locked_q;
   logic                hit;
   logic                bnd;

   assign hit = (win_q == COMMA_P) || (win_q == COMMA_N);
   // A hit in HUNT preloads phase 1, so phase 0 recurs exactly one symbol later.
   assign bnd = (phase_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q      <= '0;
         data_q     <= '0;
         phase_q    <= '0;
         lock_cnt_q <= '0;
         mis_cnt_q  <= '0;
         state_q    <= HUNT;
         valid_q    <= 1'b0;
         comma_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         win_q   <= {win_q[SYMBOL_W-2:0], bit_i};
         valid_q <= 1'b0;
         phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
         case (state_q)
            HUNT: begin
               if (hit) begin
                  phase_q    <= PW'(1);
                  lock_cnt_q <= LW'(1);
                  mis_cnt_q  <= '0;
                  if (LOCK_CNT == 1) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     valid_q  <= 1'b1;
                     data_q   <= win_q;
                     comma_q  <= 1'b1;
                  end else begin
                     state_q <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (bnd && hit) begin
                  lock_cnt_q <= lock_cnt_q + 1'b1;
                  if (lock_cnt_q == LW'(LOCK_CNT - 1)) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     valid_q  <= 1'b1;
                     data_q   <= win_q;
                     comma_q  <= 1'b1;
                  end
               end else if (bnd || hit) begin
                  state_q <= HUNT;
               end
            end
            LOCKED: begin
               if (bnd) begin
                  valid_q <= 1'b1;
                  data_q  <= win_q;
                  comma_q <= hit;
                  if (hit) mis_cnt_q <= '0;
               end else if (hit) begin
                  if (mis_cnt_q == MW'(MISALIGN_CNT - 1)) begin
                     state_q   <= HUNT;
                     locked_q  <= 1'b0;
                     mis_cnt_q <= '0;
                  end else begin
                     mis_cnt_q <= mis_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign comma_o  = comma_q;
   assign locked_o = locked_q;

endmodule

// File: rtl/serdes_lane.sv
// SerDes lane: MSB-first TX serialiser with idle comma fill plus comma-aligned RX; loopback RX latency SYMBOL_W+1.
// TX takes a symbol only on its one ready cycle per symbol; the sender holds valid until then. RX has no backpressure.
module serdes_lane
   import serdes_pkg::*;
#(
   parameter int                  SYMBOL_W     = 10,
   parameter logic [SYMBOL_W-1:0] COMMA_P      = K28_5_RDN,
   parameter logic [SYMBOL_W-1:0] COMMA_N      = K28_5_RDP,
   parameter int                  LOCK_CNT     = 3,
   parameter int                  MISALIGN_CNT = 2
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Loopback,
   input  logic [SYMBOL_W-1:0] i_Tx_Data,
   input  logic                i_Tx_Valid,
   output logic                o_Tx_Ready,
   output logic                o_Ser_Data,
   input  logic                i_Ser_Data,
   output logic [SYMBOL_W-1:0] o_Rx_Data,
   output logic                o_Rx_Valid,
   output logic                o_Rx_Comma,
   output logic                o_Locked
);

   localparam int CW = $clog2(SYMBOL_W);

   logic [SYMBOL_W-1:0] tx_shift_q, tx_shift_d;
   logic [CW-1:0]       tx_cnt_q, tx_cnt_d;
   logic                fill_n_q, fill_n_d;
   logic                wrap;
   logic                accept;
   logic                tx_bit;
   logic                rx_bit;

   assign wrap       = (tx_cnt_q == CW'(SYMBOL_W - 1));
   assign o_Tx_Ready = wrap && !i_Rst;
   assign accept     = i_Tx_Valid && o_Tx_Ready;
   assign tx_bit     = tx_shift_q[SYMBOL_W-1];
   assign o_Ser_Data = tx_bit;

   always_comb begin
      tx_shift_d = {tx_shift_q[SYMBOL_W-2:0], 1'b0};
      tx_cnt_d   = tx_cnt_q + 1'b1;
      fill_n_d   = fill_n_q;
      if (wrap) begin
         tx_cnt_d = '0;
         if (accept) begin
            tx_shift_d = i_Tx_Data;
         end else begin
            // Idle fill alternates disparity so the line stays DC balanced.
            tx_shift_d = fill_n_q ? COMMA_N : COMMA_P;
            fill_n_d   = !fill_n_q;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         tx_shift_q <= COMMA_P;
         tx_cnt_q   <= '0;
         fill_n_q   <= 1'b1;
      end else begin
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         fill_n_q   <= fill_n_d;
      end
   end

   assign rx_bit = i_Loopback ? tx_bit : i_Ser_Data;

   comma_aligner #(
      .SYMBOL_W     (SYMBOL_W),
      .COMMA_P      (COMMA_P),
      .COMMA_N      (COMMA_N),
      .LOCK_CNT     (LOCK_CNT),
      .MISALIGN_CNT (MISALIGN_CNT)
   ) u_aligner (
      .clk_i    (i_Clk),
      .rst_i    (i_Rst),
      .bit_i    (rx_bit),
      .data_o   (o_Rx_Data),
      .valid_o  (o_Rx_Valid),
      .comma_o  (o_Rx_Comma),
      .locked_o (o_Locked)
   );

endmodule

// File: doc/serdes_lane.md
# serdes_lane

Parametrised single-clock SerDes lane: the next generation of our serializer/deserializer pair, generalised in symbol width, with idle comma fill, comma-based word alignment with lock/loss-of-lock tracking, and an internal loopback mode. The TX side serialises one `SYMBOL_W`-bit symbol every `SYMBOL_W` clocks, MSB first. The RX side recovers symbol boundaries from K28.5 commas and delivers aligned symbols. It sits between the 8b/10b encoder/decoder and the pad/bit-rate domain, one instance per lane.

## Interface
- `SYMBOL_W`, 10: symbol width in bits; ≥4.
- `COMMA_P`, 10'b0011111010: comma, RD− (0x0FA).
- `COMMA_N`, 10'b1100000101: comma, RD+ (0x305).
- `LOCK_CNT`, 3: consecutive aligned commas to declare lock; ≥1.
- `MISALIGN_CNT`, 2: consecutive misaligned commas to drop lock; ≥1.
- `i_Clk`  in  1  the one clock; bit rate = clock rate.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_Loopback`  in  1  1 = RX bit source is the internal TX bit; 0 = `i_Ser_Data`.
- `i_Tx_Data`  in  SYMBOL_W  symbol to transmit.
- `i_Tx_Valid`  in  1  `i_Tx_Data` valid.
- `o_Tx_Ready`  out  1  lane takes a symbol this cycle.
- `o_Ser_Data`  out  1  serial TX bit.
- `i_Ser_Data`  in  1  serial RX bit.
- `o_Rx_Data`  out  SYMBOL_W  aligned received symbol.
- `o_Rx_Valid`  out  1  one-cycle strobe, `o_Rx_Data` new.
- `o_Rx_Comma`  out  1  qualifies `o_Rx_Valid`: symbol is a comma.
- `o_Locked`  out  1  RX aligned.

## Operation
- Reset values:
  - TX shift register = `COMMA_P`; bit counter = 0; `o_Ser_Data` = `COMMA_P[MSB]` = 0; `o_Tx_Ready` = 0.
  - RX window = 0; state HUNT; `o_Rx_Data` = 0; `o_Rx_Valid` = 0; `o_Rx_Comma` = 0; `o_Locked` = 0.
- TX:
  - `o_Ser_Data` = shift register MSB; shift left every cycle; bit counter runs 0..SYMBOL_W−1 and wraps.
  - `o_Tx_Ready` = (counter == SYMBOL_W−1) && !`i_Rst`. Accept = valid && ready, which loads `i_Tx_Data` at that edge.
  - With no accept at the wrap, load the idle comma, alternating `COMMA_N`/`COMMA_P` (the first fill after reset is `COMMA_N`).
  - Valid without ready is ignored; the sender holds the symbol.
- RX:
  - Bit source: `rx_bit` = `i_Loopback` ? internal TX bit : `i_Ser_Data`. Window shifts `rx_bit` into the LSB every cycle.
  - `hit` = window ∈ {`COMMA_P`, `COMMA_N`}. The boundary is a per-state phase counter mod SYMBOL_W.
- RX state machine:
  - HUNT: on `hit`, that cycle becomes the boundary; count = 1; go to CHECK. If `LOCK_CNT` == 1, go directly to LOCKED and emit.
  - CHECK: at each boundary, `hit` increments the count; reaching `LOCK_CNT` goes to LOCKED. A non-comma at a boundary, or `hit` off a boundary, returns to HUNT.
  - LOCKED, at each boundary: `o_Rx_Data` ← window, `o_Rx_Valid` = 1 for one cycle, `o_Rx_Comma` = `hit`, and an aligned `hit` clears the misalign count. The boundary that completes lock also emits its symbol.
  - LOCKED, off a boundary: `hit` increments the misalign count. Reaching `MISALIGN_CNT` goes to HUNT, drops `o_Locked`, and emits nothing that cycle.
- `o_Locked` = registered (state == LOCKED).
- Reset mid-operation: the in-flight symbol is dropped and all state returns to reset values at the next edge.
- A `i_Loopback` toggle is not special-cased; any resulting realignment goes through the misalign path.

## Timing
- TX: a symbol accepted at edge E drives its bits on `o_Ser_Data` after edges E..E+SYMBOL_W−1.
- Loopback latency: `o_Rx_Valid` for that symbol is high after edge E+SYMBOL_W+1, i.e. SYMBOL_W+1 cycles.
- Throughput: one symbol per SYMBOL_W cycles; `o_Tx_Ready` is high exactly 1 cycle in SYMBOL_W.
- Lock from reset in loopback (edge 1 = first edge with `i_Rst` low): `o_Locked` and the first `o_Rx_Valid` rise after edge LOCK_CNT·SYMBOL_W+1. That is edge 31 for the defaults.

## Structure
- `serdes_pkg`: `K28_5_RDN`/`K28_5_RDP` constants and `typedef enum {HUNT, CHECK, LOCKED} rx_state_t`.
- One sub-module, `comma_aligner`: the RX window, phase counter, state machine and outputs. TX stays inline in `serdes_lane`.

## Test plan
All scenarios use the default parameters.
- Reset, loopback, idle: `o_Locked` rises after edge 31. `o_Rx_Valid` then strobes every 10 cycles with `o_Rx_Comma` = 1 and data alternating 0x0FA/0x305 (0x0FA on the locking strobe).
- After lock, accept 0x2AA: `o_Rx_Data` = 0x2AA, `o_Rx_Valid` = 1, `o_Rx_Comma` = 0, exactly 11 cycles after the accept edge.
- Valid held high with 0x155, 0x2AA, 0x0F0: each is accepted once on the ready cycles, received in order 10 cycles apart, with no comma between them.
- External input (`i_Loopback` = 0), comma stream then one extra bit inserted: two misaligned commas drop `o_Locked`. It re-locks after 3 commas at the new phase, and no `o_Rx_Valid` occurs while unlocked.
- In CHECK, drive 0x155 at the second boundary: return to HUNT, `o_Locked` stays 0; lock follows only after 3 fresh consecutive commas.
- Assert `i_Rst` mid-symbol while locked: at the next edge all outputs take their reset values (`o_Ser_Data` = 0). Re-lock timing after release matches the first scenario.
